cam_filter_scheduler: RTL and testbench
=======================================

Name: cam_filter_scheduler

Overview:
- Selects which camera pixel filter (maple, snow, etc.) drives the VGA path, and when the selection changes.
- Arbitrates three requesters: piano key (valid/ready), "next" button pulse, and an auto-cycle timer. Priority is key > button > auto.
- Changes commit only on a v_sync rising edge, so a frame never mixes filters. A minimum-hold window limits flicker.
- Also provides the shared frame counter and animation tick used by the filters' timers. Sits between the input/keypad logic and the filter mux.

Parameters:
- NUM_FILTERS, 8: number of selectable filters; ids 0..NUM_FILTERS-1; at most 8.
- DEFAULT_SEL, 0: filter_sel value after reset.
- HOLD_FRAMES, 4: frames after a commit during which no further commit occurs.
- AUTO_FRAMES, 120: auto-cycle period in frames.
- ANIM_DIV_LOG2, 3: anim_tick fires once every 2^ANIM_DIV_LOG2 frames.

Ports:
- clk, input, 1: pixel/system clock.
- reset, input, 1: asynchronous, active-high.
- v_sync, input, 1: VGA vertical sync, synchronous to clk.
- key_valid, input, 1: piano key filter request.
- key_id, input, 3: requested filter id.
- key_ready, output, 1: request accepted when key_valid && key_ready.
- btn_next, input, 1: one-cycle pulse (already debounced) meaning "next filter".
- auto_en, input, 1: level; enables auto-cycling.
- filter_sel, output, 3: active filter id.
- sel_changed, output, 1: one-cycle pulse in the cycle filter_sel takes a new value.
- pending, output, 1: a request is latched and awaiting commit.
- key_err, output, 1: one-cycle pulse when an accepted key_id is >= NUM_FILTERS.
- frame_cnt, output, 10: frame counter.
- anim_tick, output, 1: one-cycle animation pulse.

Behaviour:
- Reset values:
  - filter_sel=DEFAULT_SEL.
  - sel_changed, pending, key_err, anim_tick all 0; frame_cnt=0.
  - key_ready=1.
  - Internal: v_sync_d=1, so v_sync held high out of reset is not an edge. hold_cnt=0, auto_cnt=0, pend_valid=0, state=S_IDLE.
  - Reset mid-operation discards any pending request and hold.
- vs_rise = v_sync && !v_sync_d.
  - frame_cnt increments on vs_rise and wraps 1023->0.
  - anim_tick=1 on the vs_rise cycle when frame_cnt[ANIM_DIV_LOG2-1:0]==0, using the pre-increment value. First tick is on the first frame after reset.
- Pending register fields: pend_kind in {KEY, BTN, AUTO} and pend_id. It is loaded only from registered state and inputs.
- A request arriving in the same cycle as vs_rise is latched but does not commit on that edge. The commit decision uses pend_valid as registered before the edge.
- key_ready = !pend_valid || pend_kind != KEY. A key request overwrites a pending BTN or AUTO request.
- Accepted key with key_id >= NUM_FILTERS: handshake completes, key_err pulses the next cycle, and the pending state is unchanged.
- btn_next is ignored when pend_valid=1. If btn_next and an accepted key arrive in the same cycle, the key wins and btn_next is dropped.
- Auto-cycle:
  - auto_cnt increments on vs_rise while auto_en=1.
  - When auto_cnt==AUTO_FRAMES-1 at a vs_rise: auto_cnt<=0, and an AUTO request is latched if pend_valid=0; otherwise it is dropped.
  - auto_cnt<=0 when auto_en=0 and on any KEY or BTN commit.
- Target at commit:
  - KEY: pend_id.
  - BTN or AUTO: (filter_sel+1) mod NUM_FILTERS, computed at commit time, so NUM_FILTERS-1 wraps to 0.
- Committing the current value still updates hold and pulses sel_changed.
- FSM; transitions are evaluated every cycle, and commits/decrements happen only at vs_rise:
  - S_IDLE (no pending, hold 0): on request -> S_PEND.
  - S_PEND: at vs_rise -> commit; filter_sel and sel_changed are registered on that edge; hold_cnt<=HOLD_FRAMES; go to S_HOLD, or S_HOLD_PEND if a new request arrives in the same cycle.
  - S_HOLD: at vs_rise, hold_cnt--. When hold_cnt reaches 0 -> S_IDLE. On request -> S_HOLD_PEND.
  - S_HOLD_PEND: at vs_rise, hold_cnt--. When hold_cnt==0 at vs_rise -> commit as in S_PEND.
- With HOLD_FRAMES=0, S_PEND commits go directly to S_IDLE/S_PEND.
- pending = pend_valid, i.e. state is S_PEND or S_HOLD_PEND.

Test Plan:
- Key entry and commit:
  - Stimulus: reset; key_valid=1, key_id=5 for one cycle mid-frame.
  - Response: key_ready=1, pending=1, filter_sel stays 0. At the next vs_rise, filter_sel=5 and sel_changed pulses for exactly 1 cycle.
- Hold window:
  - Stimulus: commit to 5; btn_next at frame+1 (HOLD_FRAMES=4).
  - Response: filter_sel stays 5 for 4 vs_rise edges, then becomes 6 at the 5th. key_ready stays 1 throughout.
- Override and priority:
  - Stimulus (a): btn_next pending, then key_id=2 accepted before vs_rise. Response: commit yields 2.
  - Stimulus (b): same-cycle key_id=3 and btn_next. Response: 3.
  - Stimulus (c): a second key while a key is pending. Response: key_ready=0.
- Wrap and error:
  - Stimulus (a): filter_sel=7, btn_next. Response: 0.
  - Stimulus (b): key_id=7 with NUM_FILTERS=6. Response: key_err pulses once; filter_sel is unchanged.
- Auto-cycle:
  - Stimulus: AUTO_FRAMES=3, HOLD_FRAMES=0, auto_en=1.
  - Response: AUTO request latched at vs_rise #3, commit at #4 (sel 0->1); next commit at #7. Dropping auto_en clears auto_cnt.
- Counters, edges, reset:
  - Stimulus (a): v_sync high during reset. Response: no spurious vs_rise.
  - Stimulus (b): run 1024 frames. Response: frame_cnt wraps to 0; anim_tick occurs on frames 0, 8, 16, ….
  - Stimulus (c): reset asserted while in S_HOLD_PEND. Response: filter_sel=DEFAULT_SEL, pending=0.

Source files
------------

// File: rtl/cam_filter_scheduler.sv
// rtl/cam_filter_scheduler.sv - filter select arbiter (key > button > auto) committing on v_sync rise
module cam_filter_scheduler #(
  parameter int NUM_FILTERS   = 8,
  parameter int DEFAULT_SEL   = 0,
  parameter int HOLD_FRAMES   = 4,
  parameter int AUTO_FRAMES   = 120,
  parameter int ANIM_DIV_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       key_valid,
  input  logic [2:0] key_id,
  output logic       key_ready,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic [2:0] filter_sel,
  output logic       sel_changed,
  output logic       pending,
  output logic       key_err,
  output logic [9:0] frame_cnt,
  output logic       anim_tick
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_HOLD, S_HOLD_PEND} state_t;
  typedef enum logic [1:0] {K_KEY, K_BTN, K_AUTO} kind_t;

  localparam logic [2:0]  LAST_ID   = 3'(NUM_FILTERS - 1);
  localparam logic [2:0]  RESET_SEL = 3'(DEFAULT_SEL);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

  state_t      state, state_n;
  kind_t       pend_kind;
  logic [2:0]  pend_id;
  logic        v_sync_d;
  logic [7:0]  hold_cnt;
  logic [15:0] auto_cnt;
  logic        vs_rise, pend_valid, key_acc, key_ok, btn_req;
  logic        auto_wrap, auto_req, new_req, commit;
  logic [2:0]  next_id, commit_id;

  assign vs_rise    = v_sync && !v_sync_d;
  assign pend_valid = (state == S_PEND) || (state == S_HOLD_PEND);
  assign pending    = pend_valid;
  assign key_ready  = !pend_valid || (pend_kind != K_KEY);
  assign key_acc    = key_valid && key_ready;
  assign key_ok     = key_acc && ({29'd0, key_id} < 32'(NUM_FILTERS));
  // An accepted key, even an invalid one, suppresses lower-priority requests.
  assign btn_req    = btn_next && !pend_valid && !key_acc;
  assign auto_wrap  = vs_rise && auto_en && (auto_cnt == AUTO_LAST);
  assign auto_req   = auto_wrap && !pend_valid && !key_acc && !btn_req;
  assign new_req    = key_ok || btn_req || auto_req;
  assign anim_tick  = vs_rise && (frame_cnt[ANIM_DIV_LOG2-1:0] == '0);
  assign next_id    = (filter_sel == LAST_ID) ? 3'd0 : filter_sel + 3'd1;
  assign commit_id  = (pend_kind == K_KEY) ? pend_id : next_id;

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      S_IDLE: if (new_req) state_n = S_PEND;
      S_PEND: if (vs_rise) commit = 1'b1;
      S_HOLD: begin
        if (vs_rise && hold_cnt <= 8'd1) state_n = new_req ? S_PEND : S_IDLE;
        else if (new_req)                state_n = S_HOLD_PEND;
      end
      S_HOLD_PEND: if (vs_rise && hold_cnt == 8'd0) commit = 1'b1;
      default: state_n = S_IDLE;
    endcase
    if (commit) begin
      if (HOLD_FRAMES == 0) state_n = new_req ? S_PEND : S_IDLE;
      else                  state_n = new_req ? S_HOLD_PEND : S_HOLD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pend_kind   <= K_BTN;
      pend_id     <= 3'd0;
      v_sync_d    <= 1'b1;
      hold_cnt    <= 8'd0;
      auto_cnt    <= 16'd0;
      filter_sel  <= RESET_SEL;
      sel_changed <= 1'b0;
      key_err     <= 1'b0;
      frame_cnt   <= 10'd0;
    end else begin
      state       <= state_n;
      v_sync_d    <= v_sync;
      sel_changed <= commit;
      key_err     <= key_acc && !key_ok;
      if (vs_rise) frame_cnt <= frame_cnt + 10'd1;
      if (commit) filter_sel <= commit_id;

      if (commit)                        hold_cnt <= HOLD_INIT;
      else if (vs_rise && hold_cnt != 0) hold_cnt <= hold_cnt - 8'd1;

      if (key_ok) begin
        pend_kind <= K_KEY;
        pend_id   <= key_id;
      end else if (btn_req) begin
        pend_kind <= K_BTN;
      end else if (auto_req) begin
        pend_kind <= K_AUTO;
      end

      // Manual selections restart the auto-cycle period; auto commits do not.
      if (!auto_en || (commit && pend_kind != K_AUTO)) auto_cnt <= 16'd0;
      else if (vs_rise) auto_cnt <= auto_wrap ? 16'd0 : auto_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_filter_scheduler.sv
// tb/tb_cam_filter_scheduler.sv - randomized scoreboard bench for cam_filter_scheduler (two parameter sets)
module tb_cam_filter_scheduler;

  localparam int NI = 2;
  localparam int NF_A = 6, DEF_A = 2, HOLD_A = 3, AUTO_A = 5, ANIM_A = 3;
  localparam int NF_B = 8, DEF_B = 0, HOLD_B = 0, AUTO_B = 3, ANIM_B = 2;

  typedef struct packed {
    logic       key_ready;
    logic [2:0] filter_sel;
    logic       sel_changed;
    logic       pending;
    logic       key_err;
    logic [9:0] frame_cnt;
    logic       anim_tick;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v_sync = 1'b1;
  logic       key_valid = 1'b0;
  logic [2:0] key_id = 3'd0;
  logic       btn_next = 1'b0;
  logic       auto_en = 1'b0;

  logic       d_key_ready [NI];
  logic [2:0] d_filter_sel [NI];
  logic       d_sel_changed [NI];
  logic       d_pending [NI];
  logic       d_key_err [NI];
  logic [9:0] d_frame_cnt [NI];
  logic       d_anim_tick [NI];

  always #5 clk = ~clk;

  cam_filter_scheduler #(.NUM_FILTERS(NF_A), .DEFAULT_SEL(DEF_A), .HOLD_FRAMES(HOLD_A),
                         .AUTO_FRAMES(AUTO_A), .ANIM_DIV_LOG2(ANIM_A)) u_a (
    .clk(clk), .reset(reset), .v_sync(v_sync), .key_valid(key_valid), .key_id(key_id),
    .key_ready(d_key_ready[0]), .btn_next(btn_next), .auto_en(auto_en),
    .filter_sel(d_filter_sel[0]), .sel_changed(d_sel_changed[0]), .pending(d_pending[0]),
    .key_err(d_key_err[0]), .frame_cnt(d_frame_cnt[0]), .anim_tick(d_anim_tick[0]));

  cam_filter_scheduler #(.NUM_FILTERS(NF_B), .DEFAULT_SEL(DEF_B), .HOLD_FRAMES(HOLD_B),
                         .AUTO_FRAMES(AUTO_B), .ANIM_DIV_LOG2(ANIM_B)) u_b (
    .clk(clk), .reset(reset), .v_sync(v_sync), .key_valid(key_valid), .key_id(key_id),
    .key_ready(d_key_ready[1]), .btn_next(btn_next), .auto_en(auto_en),
    .filter_sel(d_filter_sel[1]), .sel_changed(d_sel_changed[1]), .pending(d_pending[1]),
    .key_err(d_key_err[1]), .frame_cnt(d_frame_cnt[1]), .anim_tick(d_anim_tick[1]));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  obs_t       q0[$], q1[$];
  logic [2:0] cq0[$], cq1[$];

  // Reference model: a pending request, frames of hold left, and counters.
  int c_nf[NI], c_def[NI], c_hold[NI], c_auto[NI], c_anim[NI];
  int m_sel[NI], m_pv[NI], m_pk[NI], m_pid[NI], m_hold[NI], m_auto[NI], m_frame[NI];
  int m_chg[NI], m_err[NI];
  int m_vsd;
  logic ae;

  localparam int KEY = 0, BTN = 1, AUTO = 2, NONE = 3;

  task automatic model_reset(input int i);
    m_sel[i] = c_def[i]; m_pv[i] = 0; m_pk[i] = BTN; m_pid[i] = 0;
    m_hold[i] = 0; m_auto[i] = 0; m_frame[i] = 0; m_chg[i] = 0; m_err[i] = 0;
  endtask

  task automatic model_push(input int i, input obs_t e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic model_cycle(input int i, input logic r, input logic vsr, input logic kv,
                             input logic [2:0] kid, input logic bn, input logic aen);
    obs_t e;
    int ready, acc, commit, auto_hit, nk, target;
    if (r) begin
      model_reset(i);
      if (i == 0) cq0.delete(); else cq1.delete();
      e.key_ready = 1'b1; e.filter_sel = 3'(c_def[i]); e.sel_changed = 1'b0;
      e.pending = 1'b0; e.key_err = 1'b0; e.frame_cnt = 10'd0; e.anim_tick = 1'b0;
      model_push(i, e);
      return;
    end
    ready = (!m_pv[i] || m_pk[i] != KEY) ? 1 : 0;
    e.key_ready   = ready[0];
    e.filter_sel  = 3'(m_sel[i]);
    e.sel_changed = m_chg[i][0];
    e.pending     = m_pv[i][0];
    e.key_err     = m_err[i][0];
    e.frame_cnt   = 10'(m_frame[i]);
    e.anim_tick   = vsr && ((m_frame[i] % (1 << c_anim[i])) == 0);
    model_push(i, e);

    acc      = (kv && ready) ? 1 : 0;
    commit   = (vsr && m_pv[i] && m_hold[i] == 0) ? 1 : 0;
    auto_hit = (vsr && aen && m_auto[i] == c_auto[i] - 1) ? 1 : 0;
    m_chg[i] = commit;
    m_err[i] = (acc && int'(kid) >= c_nf[i]) ? 1 : 0;
    if (commit) begin
      target = (m_pk[i] == KEY) ? m_pid[i] : (m_sel[i] + 1) % c_nf[i];
      m_sel[i] = target;
      if (i == 0) cq0.push_back(3'(target)); else cq1.push_back(3'(target));
    end
    if (acc && int'(kid) < c_nf[i]) nk = KEY;
    else if (!acc && bn && !m_pv[i]) nk = BTN;
    else if (!acc && !m_pv[i] && auto_hit) nk = AUTO;
    else nk = NONE;
    if (commit) m_hold[i] = c_hold[i];
    else if (vsr && m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
    if (!aen || (commit && m_pk[i] != AUTO)) m_auto[i] = 0;
    else if (vsr) m_auto[i] = auto_hit ? 0 : m_auto[i] + 1;
    if (nk != NONE) begin
      m_pv[i] = 1; m_pk[i] = nk;
      if (nk == KEY) m_pid[i] = int'(kid);
    end else if (commit) begin
      m_pv[i] = 0;
    end
    if (vsr) m_frame[i] = (m_frame[i] + 1) % 1024;
  endtask

  task automatic step(input logic r, input logic vs, input logic kv, input logic [2:0] kid,
                      input logic bn);
    logic vsr;
    @(posedge clk);
    #1;
    reset = r; v_sync = vs; key_valid = kv; key_id = kid; btn_next = bn; auto_en = ae;
    vsr = !r && vs && (m_vsd == 0);
    for (int i = 0; i < NI; i++) model_cycle(i, r, vsr, kv, kid, bn, ae);
    m_vsd = (r || vs) ? 1 : 0;
    cyc++;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      step(0, 1, 0, 3'd0, 0);
      repeat (3) step(0, 0, 0, 3'd0, 0);
    end
  endtask

  task automatic rand_frames(input int n, input logic rst_en);
    int len, hi;
    logic r, kv, bn;
    for (int f = 0; f < n; f++) begin
      len = $urandom_range(3, 8);
      hi  = $urandom_range(1, 2);
      for (int c = 0; c < len; c++) begin
        kv = ($urandom_range(0, 9) == 0);
        bn = ($urandom_range(0, 11) == 0);
        r  = rst_en && ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 199) == 0) ae = !ae;
        step(r, c < hi, kv, 3'($urandom_range(0, 7)), bn);
      end
    end
  endtask

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.key_ready = d_key_ready[i]; o.filter_sel = d_filter_sel[i];
    o.sel_changed = d_sel_changed[i]; o.pending = d_pending[i]; o.key_err = d_key_err[i];
    o.frame_cnt = d_frame_cnt[i]; o.anim_tick = d_anim_tick[i];
    return o;
  endfunction

  obs_t       mon_got, mon_exp;
  logic [2:0] mon_ce;
  logic       mon_have;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      mon_got  = get_obs(i);
      mon_have = 1'b0;
      if (i == 0 && q0.size() > 0) begin mon_exp = q0.pop_front(); mon_have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin mon_exp = q1.pop_front(); mon_have = 1'b1; end
      if (mon_have) begin
        checks++;
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL outputs dut%0d cyc=%0d got rdy=%b sel=%0d chg=%b pend=%b err=%b frame=%0d tick=%b required rdy=%b sel=%0d chg=%b pend=%b err=%b frame=%0d tick=%b",
                   i, cyc, mon_got.key_ready, mon_got.filter_sel, mon_got.sel_changed,
                   mon_got.pending, mon_got.key_err, mon_got.frame_cnt, mon_got.anim_tick,
                   mon_exp.key_ready, mon_exp.filter_sel, mon_exp.sel_changed,
                   mon_exp.pending, mon_exp.key_err, mon_exp.frame_cnt, mon_exp.anim_tick);
        end
      end
      if (mon_got.sel_changed === 1'b1) begin
        checks++;
        mon_have = 1'b0;
        if (i == 0 && cq0.size() > 0) begin mon_ce = cq0.pop_front(); mon_have = 1'b1; end
        if (i == 1 && cq1.size() > 0) begin mon_ce = cq1.pop_front(); mon_have = 1'b1; end
        if (!mon_have) begin
          errors++;
          $display("FAIL commit dut%0d cyc=%0d got sel_changed with sel=%0d required no commit",
                   i, cyc, mon_got.filter_sel);
        end else if (mon_got.filter_sel !== mon_ce) begin
          errors++;
          $display("FAIL commit dut%0d cyc=%0d got sel=%0d required sel=%0d",
                   i, cyc, mon_got.filter_sel, mon_ce);
        end
      end
    end
  end

  initial begin
    c_nf   = '{NF_A, NF_B};     c_def  = '{DEF_A, DEF_B};   c_hold = '{HOLD_A, HOLD_B};
    c_auto = '{AUTO_A, AUTO_B}; c_anim = '{ANIM_A, ANIM_B};
    for (int i = 0; i < NI; i++) model_reset(i);
    m_vsd = 1;
    ae = 1'b0;

    // v_sync high through and after reset must not look like an edge
    repeat (3) step(1, 1, 0, 3'd0, 0);
    repeat (4) step(0, 1, 0, 3'd0, 0);
    repeat (3) step(0, 0, 0, 3'd0, 0);

    // key 5 mid-frame, commit, then button inside the hold window
    step(0, 0, 1, 3'd5, 0);
    repeat (2) step(0, 0, 0, 3'd0, 0);
    frames(1);
    step(0, 0, 0, 3'd0, 1);
    frames(6);

    // key overrides pending button; same-cycle key and button; second key refused
    step(0, 0, 0, 3'd0, 1);
    step(0, 0, 1, 3'd2, 0);
    frames(5);
    step(0, 0, 1, 3'd3, 1);
    step(0, 0, 1, 3'd4, 0);
    frames(5);

    // out-of-range key for the 6-filter instance, then wrap from 7
    step(0, 0, 1, 3'd7, 0);
    frames(5);
    step(0, 0, 0, 3'd0, 1);
    frames(5);

    // auto-cycling, then disabling it
    ae = 1'b1;
    frames(14);
    ae = 1'b0;
    frames(2);
    ae = 1'b1;
    frames(4);

    // reset while a request waits behind the hold window
    ae = 1'b0;
    step(0, 0, 1, 3'd1, 0);
    frames(1);
    step(0, 0, 0, 3'd0, 1);
    step(1, 0, 0, 3'd0, 0);
    step(0, 0, 0, 3'd0, 0);
    frames(2);

    // long randomized run crosses the 1023->0 frame wrap, then random resets
    ae = 1'b1;
    rand_frames(1100, 1'b0);
    rand_frames(200, 1'b1);

    repeat (4) step(0, 0, 0, 3'd0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || cq0.size() != 0 || cq1.size() != 0) begin
      errors++;
      $display("FAIL drain got q=%0d/%0d commits=%0d/%0d left required 0",
               q0.size(), q1.size(), cq0.size(), cq1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
